// File: rtl/wavetable_interp_reader.sv
// Multi-voice wavetable reader: two adjacent reads from one shared ROM per request,
// linear interpolation on the fractional phase, tagged result at fixed latency 4.
module wavetable_interp_reader #(
  parameter int    N_LUT      = 10,
  parameter int    FRAC_W     = 8,
  parameter int    DATA_W     = 24,
  parameter int    NUM_WAVES  = 4,
  parameter int    NUM_BANDS  = 22,
  parameter int    NUM_VOICES = 8,
  parameter string FILE       = "wavetable_lut.hex",
  localparam int   VID_W      = $clog2(NUM_VOICES),
  localparam int   WAVE_W     = $clog2(NUM_WAVES),
  localparam int   BAND_W     = $clog2(NUM_BANDS),
  localparam int   PH_W       = N_LUT + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VID_W-1:0]  in_voice,
  input  logic [WAVE_W-1:0] in_wave,
  input  logic [BAND_W-1:0] in_band,
  input  logic [PH_W-1:0]   in_phase,
  output logic              out_valid,
  output logic [VID_W-1:0]  out_voice,
  output logic [DATA_W-1:0] out_data
);

  localparam int NUM_TBL   = (NUM_WAVES - 1) * NUM_BANDS + 1;
  localparam int TBL_W     = $clog2(NUM_TBL);
  localparam int ADDR_W    = TBL_W + N_LUT;
  localparam int ROM_DEPTH = NUM_TBL << N_LUT;
  localparam int PROD_W    = DATA_W + FRAC_W + 2;

  typedef enum logic {IDLE, RD1} state_t;

  logic [DATA_W-1:0] rom [ROM_DEPTH];

  state_t state;
  logic   accept;
  logic   v0, v1, v2, v3;

  logic [BAND_W-1:0] band_c;
  logic [TBL_W-1:0]  tbl;
  logic [N_LUT-1:0]  idx, idx_nx;

  logic [ADDR_W-1:0]        rd_addr, addr1_r;
  logic [VID_W-1:0]         a_voice, p_voice, q_voice;
  logic [FRAC_W-1:0]        a_frac, p_frac;
  logic [DATA_W-1:0]        rom_q, s0_r;
  logic signed [DATA_W-1:0] s0_p;
  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] prod_c, prod_r;

  assign accept = in_valid && (state == IDLE);

  // The table number forms the upper address bits, so an N_LUT-bit index
  // increment wraps inside the table rather than spilling into the next one.
  always_comb begin
    band_c = (in_band > BAND_W'(NUM_BANDS - 1)) ? BAND_W'(NUM_BANDS - 1) : in_band;
    if (in_wave >= WAVE_W'(NUM_WAVES - 1))
      tbl = TBL_W'((NUM_WAVES - 1) * NUM_BANDS);
    else
      tbl = TBL_W'(in_wave) * TBL_W'(NUM_BANDS) + TBL_W'(band_c);
    idx    = in_phase[PH_W-1:FRAC_W];
    idx_nx = idx + N_LUT'(1);
  end

  always_comb begin
    diff   = $signed({rom_q[DATA_W-1], rom_q}) - $signed({s0_r[DATA_W-1], s0_r});
    prod_c = PROD_W'(diff) * PROD_W'($signed({1'b0, p_frac}));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_voice <= '0;
      out_data  <= '0;
    end else begin
      v0 <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          state    <= RD1;
          in_ready <= 1'b0;
          v0       <= 1'b1;
        end
        RD1: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
      v1        <= v0;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        out_voice <= q_voice;
        out_data  <= s0_p + DATA_W'(prod_r >>> FRAC_W);
      end
    end
  end

  // Free-running stages: each request's data sits in a given stage on a known
  // edge, and the next request cannot overwrite it before it has moved on.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_addr <= {tbl, idx};
      addr1_r <= {tbl, idx_nx};
      a_voice <= in_voice;
      a_frac  <= in_phase[FRAC_W-1:0];
    end else if (state == RD1) begin
      rd_addr <= addr1_r;
    end
    rom_q   <= rom[rd_addr];
    s0_r    <= rom_q;
    p_voice <= a_voice;
    p_frac  <= a_frac;
    s0_p    <= $signed(s0_r);
    prod_r  <= prod_c;
    q_voice <= p_voice;
  end

endmodule

// File: tb/tb_wavetable_interp_reader.sv
// Randomized bench for wavetable_interp_reader against an arithmetic reference
// model of the table layout and interpolation, with a timed result scoreboard.
module tb_wavetable_interp_reader;

  localparam int LUT_LEN   = 1024;
  localparam int NB        = 22;
  localparam int NW        = 4;
  localparam int ROM_WORDS = ((NW - 1) * NB + 1) * LUT_LEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_voice = '0;
  logic [1:0]  in_wave = '0;
  logic [4:0]  in_band = '0;
  logic [17:0] in_phase = '0;
  logic        out_valid;
  logic [2:0]  out_voice;
  logic [23:0] out_data;

  wavetable_interp_reader #(
    .N_LUT(10), .FRAC_W(8), .DATA_W(24), .NUM_WAVES(4),
    .NUM_BANDS(22), .NUM_VOICES(8), .FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_voice(in_voice), .in_wave(in_wave), .in_band(in_band), .in_phase(in_phase),
    .out_valid(out_valid), .out_voice(out_voice), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int voice;
    int data;
    int due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_v_cyc = -10;
  bit   ready_exp = 1'b1;
  int   held_data = 0;
  int   held_voice = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rom_val(input int a);
    return 256 * (a % LUT_LEN) + 4 * (a / LUT_LEN);
  endfunction

  function automatic int model(input int wave, input int band, input int phase);
    int idx, frac, b, t, s0, s1, p, fl;
    idx  = phase / 256;
    frac = phase % 256;
    b    = (band > NB - 1) ? NB - 1 : band;
    t    = (wave >= NW - 1) ? (NW - 1) * NB : wave * NB + b;
    s0   = rom_val(t * LUT_LEN + idx);
    s1   = rom_val(t * LUT_LEN + (idx + 1) % LUT_LEN);
    p    = (s1 - s0) * frac;
    fl   = p / 256;
    if (p < 0 && (p % 256) != 0) fl = fl - 1;
    return (s0 + fl) & 24'hFFFFFF;
  endfunction

  task automatic step(input bit rn, input bit v, input int voice, input int wave,
                      input int band, input int phase);
    exp_t e;
    bit   acc, exp_v;
    rst_n    = rn;
    in_valid = v;
    in_voice = 3'(voice);
    in_wave  = 2'(wave);
    in_band  = 5'(band);
    in_phase = 18'(phase);
    @(posedge clk);
    cyc++;
    if (!rn) begin
      q.delete();
      ready_exp  = 1'b1;
      held_data  = 0;
      held_voice = 0;
    end else begin
      acc = v && ready_exp;
      if (acc) begin
        e.voice = voice;
        e.data  = model(wave, band, phase);
        e.due   = cyc + 4;
        q.push_back(e);
      end
      ready_exp = !acc;
    end
    @(negedge clk);
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    check("in_ready", 64'(in_ready), 64'(ready_exp));
    check("out_valid", 64'(out_valid), 64'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      check("out_voice", 64'(out_voice), 64'(e.voice));
      check("out_data", 64'(out_data), 64'(e.data));
      held_data  = e.data;
      held_voice = e.voice;
    end else begin
      check("held_data", 64'(out_data), 64'(held_data));
      check("held_voice", 64'(out_voice), 64'(held_voice));
    end
    if (out_valid) begin
      check("valid_gap_ge2", 64'(cyc - last_v_cyc >= 2), 64'(1));
      last_v_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    int nv;
    bit was_ready;
    for (int a = 0; a < ROM_WORDS; a++) dut.rom[a] = 24'(rom_val(a));

    step(1'b0, 1'b1, 3, 1, 2, 1234);
    step(1'b0, 1'b0, 0, 0, 0, 0);

    // interpolation midway, in-table wrap, band select and clamp, sine
    step(1'b1, 1'b1, 5, 0, 0, (5 << 8) | 8'h80);    idle(5);
    step(1'b1, 1'b1, 1, 0, 0, (1023 << 8) | 8'h40); idle(5);
    step(1'b1, 1'b1, 2, 1, 3, 10 << 8);             idle(1);
    step(1'b1, 1'b1, 3, 1, 30, 10 << 8);            idle(5);
    step(1'b1, 1'b1, 4, 3, 7, (2 << 8) | 8'hFF);    idle(5);

    // valid held high: one accept per two cycles, voices in order
    nv = 0;
    for (int i = 0; i < 24 && nv < 8; i++) begin
      was_ready = ready_exp;
      step(1'b1, 1'b1, nv, i % 4, i, (i * 9173) % 262144);
      if (was_ready) nv++;
    end
    check("burst_accepts", 64'(nv), 64'(8));
    idle(6);

    // reset while the request is in RD1, then a clean request
    step(1'b1, 1'b1, 6, 2, 4, (100 << 8) | 17);
    step(1'b0, 1'b0, 0, 0, 0, 0);
    idle(6);
    step(1'b1, 1'b1, 7, 0, 5, (300 << 8) | 200);
    idle(6);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 262143)));
    idle(8);
    check("queue_drained", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
